sipo_deserializer: RTL and testbench
====================================

// Module: sipo_deserializer
//
// PURPOSE
//   Receive-side counterpart of the universal shift register. Takes a
//   bit-serial stream (one bit per ser_valid strobe) and reassembles it into
//   WIDTH-bit words. Bit order is selectable per frame (MSB-first or LSB-first).
//   Completed words are presented on a valid/ready output port that holds one
//   word. Sits between a serial link and the parallel datapath.
//
// PARAMETERS
//   WIDTH   8   word length in bits (>=2); bit counter is clog2(WIDTH)+1 bits
//
// PORTS
//   clk         in   1      rising-edge clock (single clock domain)
//   rst_n       in   1      synchronous reset, active-low
//   ser_in      in   1      serial data bit, sampled when ser_valid=1
//   ser_valid   in   1      bit strobe: ser_in is accepted on this clk edge
//   msb_first   in   1      1: first bit becomes word MSB; 0: first bit becomes LSB
//   clear       in   1      abort partial frame (sync, active-high)
//   par_out     out  WIDTH  assembled word (output holding register)
//   out_valid   out  1      par_out holds an unconsumed word
//   out_ready   in   1      consumer accepts par_out when out_valid & out_ready
//   busy        out  1      partial frame in progress (bit count != 0)
//   overrun     out  1      one-cycle pulse: completed word dropped, output full
//
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): shift reg, bit count, par_out=0; out_valid=0,
//     busy=0, overrun=0; frame order register=0. Reset has priority over all
//     inputs and discards a partial frame and any held word.
//   - Frame order: msb_first is latched on the edge that accepts bit 0 of a frame
//     (count==0 & ser_valid). It is ignored for the rest of the frame.
//   - Shift, MSB-first: sr <= {sr[WIDTH-2:0], ser_in}.
//     Shift, LSB-first: sr <= {ser_in, sr[WIDTH-1:1]}.
//     The first bit of the frame uses the current msb_first directly.
//   - Count: increments per accepted bit. On the WIDTH-th bit, count returns to 0.
//     On that same edge, the full word (including this bit) is the completed word.
//   - Latency: par_out/out_valid update on the edge accepting the WIDTH-th bit,
//     so they are visible the following cycle. Back-to-back frames with no gap
//     are supported (ser_valid every cycle).
//   - Output handshake: a word is consumed on an edge with out_valid & out_ready.
//     par_out is stable while out_valid=1 and no consumption occurs.
//     par_out is not cleared on consumption; only out_valid drops.
//   - Completion when output is empty or consumed on the same edge: load par_out,
//     out_valid=1. Simultaneous completion + consumption keeps out_valid=1 and
//     loads the new word.
//   - Completion when out_valid=1 & !out_ready: the new word is dropped, the old
//     par_out is kept, and overrun=1 for exactly one cycle. The counter still
//     wraps to 0.
//   - clear=1: count<=0 and sr<=0. A bit presented on the same edge is discarded.
//     clear does not affect par_out/out_valid. A completing bit coincident with
//     clear is dropped (no load, no overrun). busy=0 on the next cycle.
//   - ser_valid=0: sr and count hold. Idle gaps of any length are allowed mid-frame.
//   - busy = (count != 0), registered-state derived (no ser_valid combinational path).
//   - No combinational path from any input to any output.
//
// TESTING
//   1. Reset: rst_n=0 mid-frame (3 bits in) with out_valid=1 -> next cycle
//      par_out=0, out_valid=0, busy=0; the next 8 bits form a fresh word.
//   2. MSB-first: msb_first=1, bits 1,0,1,1,0,0,0,1 on consecutive cycles ->
//      par_out=8'hB1, out_valid=1 one cycle after the 8th bit.
//   3. LSB-first: msb_first=0, same bit sequence -> par_out=8'h8D. Toggling
//      msb_first after bit 0 has no effect.
//   4. Backpressure: out_ready=0, two full frames 8'hB1 then 8'h8D -> par_out stays
//      8'hB1, overrun pulses 1 cycle at the 2nd completion. Then out_ready=1 ->
//      out_valid=0.
//   5. Simultaneous: out_valid=1 and out_ready=1 on the edge a new word
//      (8'h5A) completes -> out_valid stays 1, par_out=8'h5A, overrun=0.
//   6. Clear/gaps: 4 bits, clear=1, then 8 bits of 8'hC3 with random ser_valid
//      gaps -> par_out=8'hC3, with no contribution from the pre-clear bits.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer: assembles WIDTH-bit words from a strobed bit
// stream with per-frame bit order, presenting them on a single-entry valid/ready port.
module sipo_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             msb_first,
  input  logic             clear,
  output logic [WIDTH-1:0] par_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift;
  logic [CNT_W-1:0] count;
  logic             order_q;
  logic             order_eff;
  logic             accept;
  logic             last_bit;
  logic             out_free;

  // The first bit of a frame must use the live msb_first, since order_q is
  // only being captured on that same edge.
  always_comb begin
    accept    = ser_valid & ~clear;
    order_eff = (count == '0) ? msb_first : order_q;
    sr_shift  = order_eff ? {sr[WIDTH-2:0], ser_in} : {ser_in, sr[WIDTH-1:1]};
    last_bit  = accept && (count == CNT_W'(WIDTH - 1));
    out_free  = ~out_valid | out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr        <= '0;
      count     <= '0;
      order_q   <= 1'b0;
      par_out   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (clear) begin
        sr    <= '0;
        count <= '0;
      end else if (accept) begin
        sr <= sr_shift;
        if (count == '0)
          order_q <= msb_first;
        if (last_bit) begin
          count <= '0;
          // Completion while the holder is full and not draining drops the new word.
          if (out_free) begin
            par_out   <= sr_shift;
            out_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

  assign busy = (count != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: a frame-level model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_sipo_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, ser_in, ser_valid, msb_first, clear, out_ready;
  logic [W-1:0] par_out;
  logic         out_valid, busy, overrun;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
    .msb_first(msb_first), .clear(clear), .par_out(par_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect the bits of the current frame, build the word once full.
  bit           fbits[$];
  bit           forder;
  logic [W-1:0] m_par;
  bit           m_valid;
  bit           m_over;

  function automatic logic [W-1:0] assemble();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (forder) w[W-1-i] = fbits[i];
      else        w[i]     = fbits[i];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    bit           keep_valid;
    logic [W-1:0] w;
    if (!rst_n) begin
      fbits.delete();
      forder  = 1'b0;
      m_par   = '0;
      m_valid = 1'b0;
      m_over  = 1'b0;
    end else begin
      keep_valid = m_valid && !out_ready;
      m_over     = 1'b0;
      if (clear) begin
        fbits.delete();
      end else if (ser_valid) begin
        if (fbits.size() == 0) forder = msb_first;
        fbits.push_back(ser_in);
        if (fbits.size() == W) begin
          w = assemble();
          fbits.delete();
          if (!m_valid || out_ready) begin
            m_par      = w;
            keep_valid = 1'b1;
          end else begin
            m_over = 1'b1;
          end
        end
      end
      m_valid = keep_valid;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_par_out",   32'(par_out),   32'(m_par));
      chk("model_out_valid", 32'(out_valid), 32'(m_valid));
      chk("model_busy",      32'(busy),      32'(fbits.size() != 0));
      chk("model_overrun",   32'(overrun),   32'(m_over));
    end
  end

  // Sends one full word; idle gaps carry junk on ser_in/msb_first that must be ignored.
  task automatic send_word(input logic [W-1:0] w, input bit msb, input bit flip,
                           input bit rdy_last, input int gap_max);
    for (int i = 0; i < W; i++) begin
      if (i > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          ser_valid = 1'b0;
          ser_in    = 1'($urandom_range(0, 1));
          msb_first = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      ser_valid = 1'b1;
      ser_in    = msb ? w[W-1-i] : w[i];
      msb_first = (i > 0 && flip) ? ~msb : msb;
      if (i == W-1 && rdy_last) out_ready = 1'b1;
      @(negedge clk);
    end
    ser_valid = 1'b0;
  endtask

  task automatic send_partial(input logic [W-1:0] w, input int n, input bit clr_last);
    for (int i = 0; i < n; i++) begin
      ser_valid = 1'b1;
      ser_in    = w[W-1-i];
      msb_first = 1'b1;
      clear     = (clr_last && i == n-1);
      @(negedge clk);
    end
    ser_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; msb_first = 1'b0;
    clear = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("reset_par_out", 32'(par_out), 32'h0);
    chk("reset_valid",   32'(out_valid), 32'h0);

    // MSB-first: 1,0,1,1,0,0,0,1
    send_word(8'hB1, 1'b1, 1'b0, 1'b0, 0);
    chk("msb_par_out", 32'(par_out), 32'hB1);
    chk("msb_valid",   32'(out_valid), 32'h1);
    drain();
    chk("consume_valid", 32'(out_valid), 32'h0);

    // LSB-first, same bit sequence, msb_first toggled after bit 0
    send_word(8'h8D, 1'b0, 1'b1, 1'b0, 0);
    chk("lsb_par_out", 32'(par_out), 32'h8D);
    drain();

    // Backpressure: second completion is dropped
    send_word(8'hB1, 1'b1, 1'b0, 1'b0, 0);
    send_word(8'h8D, 1'b0, 1'b0, 1'b0, 0);
    chk("bp_overrun", 32'(overrun), 32'h1);
    chk("bp_par_out", 32'(par_out), 32'hB1);
    @(negedge clk);
    chk("bp_overrun_pulse", 32'(overrun), 32'h0);
    drain();
    chk("bp_drain_valid",  32'(out_valid), 32'h0);
    chk("bp_par_retained", 32'(par_out), 32'hB1);

    // Completion coincident with consumption
    send_word(8'h3C, 1'b1, 1'b0, 1'b0, 0);
    send_word(8'h5A, 1'b1, 1'b0, 1'b1, 0);
    out_ready = 1'b0;
    chk("simul_valid",   32'(out_valid), 32'h1);
    chk("simul_par_out", 32'(par_out), 32'h5A);
    chk("simul_overrun", 32'(overrun), 32'h0);
    drain();

    // Clear mid-frame, bit presented with clear is discarded
    send_partial(8'hFF, 4, 1'b0);
    ser_valid = 1'b1; ser_in = 1'b1; clear = 1'b1;
    @(negedge clk);
    ser_valid = 1'b0; clear = 1'b0;
    chk("clear_busy", 32'(busy), 32'h0);
    send_word(8'hC3, 1'b1, 1'b0, 1'b0, 3);
    chk("clear_par_out", 32'(par_out), 32'hC3);

    // Clear on the completing bit while full: no load, no overrun
    send_partial(8'h81, 8, 1'b1);
    chk("clr_last_overrun", 32'(overrun), 32'h0);
    chk("clr_last_par_out", 32'(par_out), 32'hC3);
    chk("clr_last_busy",    32'(busy), 32'h0);
    drain();

    // Reset mid-frame while a word is held
    send_word(8'hE7, 1'b1, 1'b0, 1'b0, 1);
    send_partial(8'hFF, 3, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_par_out", 32'(par_out), 32'h0);
    chk("rst_valid",   32'(out_valid), 32'h0);
    chk("rst_busy",    32'(busy), 32'h0);
    send_word(8'hA5, 1'b0, 1'b0, 1'b0, 2);
    chk("post_rst_par_out", 32'(par_out), 32'hA5);
    chk("post_rst_valid",   32'(out_valid), 32'h1);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
